// File: rtl/mem_access_ctrl_if.sv
// CPU-side and data-memory-side signal bundle for mem_access_ctrl.
// slave: the controller. master: the surrounding CPU/memory (or bench).
// Carries no clock; clk/rst remain plain ports on the controller.
interface mem_access_ctrl_if;
  // CPU side
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  // Data-memory side
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  // Status
  logic        fault;
  logic [7:0]  fault_count;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_memread, cpu_memwrite, cpu_sign_mask,
    input  mem_rdata, mem_stall,
    output cpu_rdata, cpu_stall,
    output mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask,
    output fault, fault_count
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_memread, cpu_memwrite, cpu_sign_mask,
    output mem_rdata, mem_stall,
    input  cpu_rdata, cpu_stall,
    input  mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask,
    input  fault, fault_count
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one CPU load/store at a time into a stalling data memory.
// Latency: 1 cycle for a misaligned request, 3 + stall cycles (min 4) otherwise.
// Backpressure: cpu_stall holds the CPU from request until the DONE cycle.
module mem_access_ctrl #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] LED_ADDR = 32'h2000
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        op_wr_q, op_wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        seen_q, seen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [7:0]  fcnt_q, fcnt_d;

  logic        req;
  logic        misalign;
  logic [7:0]  cnt_inc;
  logic        mem_done;

  assign req      = bus.cpu_memread | bus.cpu_memwrite;
  // Word needs addr[1:0]==0; half (when not word) needs addr[0]==0; byte is always aligned.
  assign misalign = (bus.cpu_sign_mask[2] && (bus.cpu_addr[1:0] != 2'b00)) ||
                    (!bus.cpu_sign_mask[2] && bus.cpu_sign_mask[1] && bus.cpu_addr[0]);
  // cnt_inc counts WAIT cycles including the current one.
  assign cnt_inc  = cnt_q + 8'd1;
  // Completion: stall was observed high earlier in WAIT and is now low.
  assign mem_done = seen_q && !bus.mem_stall;

  // State register and captured request; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state, capture, load-result and fault bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    op_wr_d = op_wr_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    fcnt_d  = fcnt_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          mask_d  = bus.cpu_sign_mask;
          // Read wins when both lines are high; the write is silently dropped.
          op_wr_d = !bus.cpu_memread;
          if (misalign) begin
            state_d = DONE;
            rdata_d = '0;
            fault_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (bus.mem_stall) seen_d = 1'b1;
        // A completion on the timeout cycle still counts as a completion.
        if (mem_done) begin
          state_d = DONE;
          if (!op_wr_q) rdata_d = bus.mem_rdata;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d = DONE;
          if (!op_wr_q) rdata_d = '1;
          fault_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // At most one fault per request, so a single saturating increment suffices.
    if (fault_d && (fcnt_q != 8'hFF)) fcnt_d = fcnt_q + 8'd1;
  end

  assign bus.cpu_stall     = ((state_q == IDLE) && req) || (state_q == ISSUE) || (state_q == WAIT);
  assign bus.cpu_rdata     = rdata_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_sign_mask = mask_q;
  assign bus.mem_memread   = (state_q == ISSUE) && !op_wr_q;
  assign bus.mem_memwrite  = (state_q == ISSUE) && op_wr_q;
  assign bus.fault         = fault_q;
  assign bus.fault_count   = fcnt_q;

  // The LED register lives in data memory, so LED writes take the normal issue path.
  a_led_issue: assert property (@(posedge clk) disable iff (rst)
    (state_q == ISSUE && op_wr_q && addr_q == LED_ADDR) |-> bus.mem_memwrite);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: driver pushes expected strobes/completions, monitor pops and compares.
module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT(255), .LED_ADDR(32'h2000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } strb_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [7:0]  fcnt;
  } done_t;

  strb_t strb_q[$];
  done_t done_q[$];

  int          checks = 0;
  int          errors = 0;
  int          mem_stall_n = 0;
  logic [31:0] mem_val = '0;
  int          fcnt_model = 0;
  logic        prev_stall = 1'b0;

  // Data-memory model: after an issue strobe, stall for mem_stall_n WAIT cycles then return data.
  always begin
    @(negedge clk);
    if (!rst && (bus.mem_memread || bus.mem_memwrite)) begin
      @(posedge clk);
      #1;
      if (mem_stall_n > 0) begin
        bus.mem_stall = 1'b1;
        repeat (mem_stall_n) @(posedge clk);
        #1;
        bus.mem_stall = 1'b0;
        bus.mem_rdata = mem_val;
      end
    end
  end

  // Monitor: issue strobes and completions (stall falling) are checked against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.mem_memread || bus.mem_memwrite) begin
        checks++;
        if (strb_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got rd=%0b wr=%0b addr=%h, required no strobe",
                   bus.mem_memread, bus.mem_memwrite, bus.mem_addr);
        end else begin
          strb_t e;
          e = strb_q.pop_front();
          if (bus.mem_memread !== e.rd || bus.mem_memwrite !== e.wr || bus.mem_addr !== e.addr ||
              bus.mem_wdata !== e.wdata || bus.mem_sign_mask !== e.mask) begin
            errors++;
            $display("FAIL strobe: got rd=%0b wr=%0b addr=%h wdata=%h mask=%b, required rd=%0b wr=%0b addr=%h wdata=%h mask=%b",
                     bus.mem_memread, bus.mem_memwrite, bus.mem_addr, bus.mem_wdata, bus.mem_sign_mask,
                     e.rd, e.wr, e.addr, e.wdata, e.mask);
          end
        end
      end
      if (prev_stall && !bus.cpu_stall) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got completion rdata=%h, required none", bus.cpu_rdata);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (bus.cpu_rdata !== d.rdata || bus.fault !== d.fault || bus.fault_count !== d.fcnt) begin
            errors++;
            $display("FAIL done: got rdata=%h fault=%0b fcnt=%0d, required rdata=%h fault=%0b fcnt=%0d",
                     bus.cpu_rdata, bus.fault, bus.fault_count, d.rdata, d.fault, d.fcnt);
          end
        end
      end else if (bus.fault) begin
        checks++;
        errors++;
        $display("FAIL fault_stray: got fault=1 outside a completion, required 0");
      end
      prev_stall = bus.cpu_stall;
    end
  end

  task automatic check_idle_outputs(input string name, input logic [7:0] exp_fcnt);
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.mem_memread !== 1'b0 ||
        bus.mem_memwrite !== 1'b0 || bus.fault !== 1'b0 || bus.fault_count !== exp_fcnt ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_sign_mask !== 4'h0) begin
      errors++;
      $display("FAIL %s: got stall=%0b rdata=%h rd=%0b wr=%0b fault=%0b fcnt=%0d addr=%h wdata=%h mask=%b, required all zero with fcnt=%0d",
               name, bus.cpu_stall, bus.cpu_rdata, bus.mem_memread, bus.mem_memwrite, bus.fault,
               bus.fault_count, bus.mem_addr, bus.mem_wdata, bus.mem_sign_mask, exp_fcnt);
    end
  endtask

  task automatic do_req(input string name, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, input int stall_n,
                        input logic [31:0] mval, input bit exp_strobe, input logic [31:0] exp_rdata,
                        input logic exp_fault, input int exp_lat);
    int lat;
    strb_t s;
    done_t d;
    mem_stall_n = stall_n;
    mem_val     = mval;
    if (exp_strobe) begin
      s.rd = rd; s.wr = wr && !rd; s.addr = addr; s.wdata = wdata; s.mask = mask;
      strb_q.push_back(s);
    end
    if (exp_fault && fcnt_model < 255) fcnt_model++;
    d.rdata = exp_rdata; d.fault = exp_fault; d.fcnt = 8'(fcnt_model);
    done_q.push_back(d);
    @(posedge clk);
    #1;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_sign_mask = mask;
    bus.cpu_memread = rd; bus.cpu_memwrite = wr;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall) break;
      lat++;
      if (lat > 400) break;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d stall cycles, required %0d", name, lat, exp_lat);
    end
    @(posedge clk);
    #1;
    bus.cpu_memread = 1'b0; bus.cpu_memwrite = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_sign_mask = '0;
    bus.cpu_memread = 1'b0; bus.cpu_memwrite = 1'b0;
    bus.mem_rdata = '0; bus.mem_stall = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state", 8'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset", 8'd0);

    // Reset while the controller sits in WAIT: request abandoned, no fault.
    mem_stall_n = 50;
    mem_val = 32'h0BAD0BAD;
    strb_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h1004, wdata: 32'h0, mask: 4'b0100});
    @(posedge clk); #1;
    bus.cpu_addr = 32'h1004; bus.cpu_sign_mask = 4'b0100; bus.cpu_memread = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cpu_memread = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_wait", 8'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("idle_after_reset", 8'd0);

    do_req("word_load",  1'b1, 1'b0, 32'h1004, 32'h0,   4'b0100, 3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 6);
    do_req("byte_store", 1'b0, 1'b1, 32'h1003, 32'hAB,  4'b0000, 2, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 5);
    do_req("rd_wr_both", 1'b1, 1'b1, 32'h1008, 32'h5555, 4'b0100, 1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 4);
    do_req("led_store",  1'b0, 1'b1, 32'h2000, 32'h3,   4'b0100, 1, 32'h77777777, 1'b1, 32'hCAFEF00D, 1'b0, 4);
    do_req("half_misal", 1'b1, 1'b0, 32'h1001, 32'h0,   4'b0010, 0, 32'h0,        1'b0, 32'h0,        1'b1, 1);
    do_req("timeout",    1'b1, 1'b0, 32'h100C, 32'h0,   4'b0100, 0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b1, 257);
    do_req("word_misal_st", 1'b0, 1'b1, 32'h1002, 32'h99, 4'b0100, 0, 32'h0,     1'b0, 32'h0,        1'b1, 1);
    do_req("shalf_load", 1'b1, 1'b0, 32'h1006, 32'h0,   4'b1010, 2, 32'hFFFF8001, 1'b1, 32'hFFFF8001, 1'b0, 5);

    repeat (5) @(posedge clk);
    checks++;
    if (strb_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d strobes and %0d completions pending, required 0 and 0",
               strb_q.size(), done_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
